// File: rtl/mem_seq_pkg.sv
// Purpose : shared encodings and defaults for the unified memory port sequencer.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mem_seq_pkg;

    // Sequencer states, 2-bit encoded.
    typedef enum logic [1:0] {
        MSQ_IDLE = 2'd0,
        MSQ_IF   = 2'd1,
        MSQ_D    = 2'd2
    } msq_state_t;

    // Default memory access length in cycles (legal 1..15).
    localparam int MSQ_LATENCY    = 4;
    // Default number of back-to-back data grants tolerated while fetch waits (legal 1..7).
    localparam int MSQ_STARVE_MAX = 2;

    // Counter width covers LATENCY-1 up to 14.
    localparam int MSQ_CNT_W    = 4;
    // Starve counter width covers STARVE_MAX up to 7.
    localparam int MSQ_STARVE_W = 3;

endpackage

// File: rtl/latency_counter.sv
// Purpose : loadable down-counter that times a fixed-latency operation; zero marks the last cycle.
// Latency : count updates one cycle after load/enable; zero is combinational from count.
// Backpressure: none; enable simply pauses the count, which saturates at 0.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset (count -> 0)
//   load, load_val    load count with load_val (takes priority over enable)
//   enable            decrement by one per cycle while non-zero
//   count, zero       current value and (count == 0) flag
module latency_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         enable,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_port_sequencer.sv
// Purpose : arbitrates fetch and data requesters onto one memory and sequences each access.
// Latency : accept edge to done pulse is LATENCY+1 cycles; LATENCY strobe cycles, then one idle done cycle.
// Backpressure: requesters hold req (level) until their done; a new grant only happens from IDLE.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset (aborts any access)
//   if_req/if_addr                   fetch request and PC; if_rdata/if_done return the instruction
//   d_req/d_we/d_addr/d_wdata        load/store request; d_rdata/d_done return load data
//   mem_addr/mem_wdata/mem_read/mem_write/mem_rdata   memory side, strobes held for the whole access
//   busy                             high during access cycles
module mem_port_sequencer
    import mem_seq_pkg::*;
#(
    parameter int LATENCY    = MSQ_LATENCY,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = MSQ_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [MSQ_CNT_W-1:0]    LOAD_VAL   = MSQ_CNT_W'(LATENCY - 1);
    localparam logic [MSQ_STARVE_W-1:0] STARVE_LIM = MSQ_STARVE_W'(STARVE_MAX);

    msq_state_t state, state_nxt;

    logic                    grant_if;
    logic                    grant_d;
    logic                    complete;
    logic [MSQ_STARVE_W-1:0] starve;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    we_q;
    logic                    count_zero;
    // Only the zero flag matters here; the raw count is left for other users of the counter.
    logic [MSQ_CNT_W-1:0]    count_unused;

    // Counter is loaded with LATENCY-1 on the accept edge, so it reads 0 in the
    // last access cycle and the following edge is the completion edge.
    latency_counter #(
        .W (MSQ_CNT_W)
    ) u_latency_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_if | grant_d),
        .load_val (LOAD_VAL),
        .enable   (busy),
        .count    (count_unused),
        .zero     (count_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MSQ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        complete  = 1'b0;
        case (state)
            MSQ_IDLE: begin
                // Data has priority, except when fetch has already lost STARVE_MAX times in a row.
                if (d_req && !(if_req && (starve == STARVE_LIM))) begin
                    grant_d   = 1'b1;
                    state_nxt = MSQ_D;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = MSQ_IF;
                end
            end
            MSQ_IF, MSQ_D: begin
                if (count_zero) begin
                    complete  = 1'b1;
                    state_nxt = MSQ_IDLE;
                end
            end
            default: begin
                state_nxt = MSQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            starve   <= '0;
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_done <= complete && (state == MSQ_IF);
            d_done  <= complete && (state == MSQ_D);

            if (grant_if) begin
                addr_q <= if_addr;
                we_q   <= 1'b0;
                starve <= '0;
            end

            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                we_q    <= d_we;
                // Only data grants that actually made fetch wait count toward starvation.
                if (if_req) begin
                    starve <= starve + 1'b1;
                end
            end

            if (complete && (state == MSQ_IF)) begin
                if_rdata <= mem_rdata;
            end

            // Stores leave d_rdata untouched.
            if (complete && (state == MSQ_D) && !we_q) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Strobes decode from state only, so they drop in the done cycle and on reset.
    assign busy      = (state != MSQ_IDLE);
    assign mem_read  = (state == MSQ_IF) || ((state == MSQ_D) && !we_q);
    assign mem_write = (state == MSQ_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
module tb_mem_port_sequencer;

    localparam int LAT  = 4;
    localparam int SMAX = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        busy;

    // LATENCY=1 instance, fetch side only exercised.
    logic        l1_if_req = 1'b0;
    logic [31:0] l1_if_addr = 32'h300;
    logic [31:0] l1_if_rdata;
    logic        l1_if_done;
    logic        l1_d_req = 1'b0;
    logic        l1_d_we = 1'b0;
    logic [31:0] l1_d_addr = '0;
    logic [31:0] l1_d_wdata = '0;
    logic [31:0] l1_unused_d_rdata;
    logic        l1_unused_d_done;
    logic [31:0] l1_unused_mem_addr;
    logic [31:0] l1_unused_mem_wdata;
    logic        l1_mem_read;
    logic        l1_unused_mem_write;
    logic [31:0] l1_mem_rdata;
    logic        l1_busy;

    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;
    int  got[$];

    always #5 clk = ~clk;

    mem_port_sequencer #(
        .LATENCY(LAT), .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_sequencer #(
        .LATENCY(1), .ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)
    ) dut_l1 (
        .clk(clk), .reset(reset),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_done(l1_if_done),
        .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_rdata(l1_unused_d_rdata), .d_done(l1_unused_d_done),
        .mem_addr(l1_unused_mem_addr), .mem_wdata(l1_unused_mem_wdata), .mem_read(l1_mem_read),
        .mem_write(l1_unused_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0040: return 32'h1234_5678;
            32'h0000_0104: return 32'h0000_ABCD;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    assign mem_rdata    = mem_read ? mem_lookup(mem_addr) : 32'h0;
    assign l1_mem_rdata = l1_mem_read ? 32'hCAFE_0001 : 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request occupies the port for LAT
    // cycles, then a done cycle follows carrying the memory word at its address.
    bit          m_acc;
    bit          m_is_d;
    bit          m_we;
    int          m_left;
    int          m_starve;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] e_if_rdata;
    logic [31:0] e_d_rdata;
    bit          e_if_done;
    bit          e_d_done;

    always @(posedge clk) begin
        if (reset) begin
            m_acc = 0; m_is_d = 0; m_we = 0; m_left = 0; m_starve = 0;
            m_addr = '0; m_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
            e_if_done = 0; e_d_done = 0;
        end else begin
            e_if_done = 0;
            e_d_done  = 0;
            if (m_acc) begin
                m_left--;
                if (m_left == 0) begin
                    m_acc = 0;
                    if (!m_is_d) begin
                        e_if_rdata = mem_lookup(m_addr);
                        e_if_done  = 1;
                    end else begin
                        e_d_done = 1;
                        if (!m_we) e_d_rdata = mem_lookup(m_addr);
                    end
                end
            end else if (d_req || if_req) begin
                m_is_d = d_req && !(if_req && (m_starve == SMAX));
                m_acc  = 1;
                m_left = LAT;
                if (m_is_d) begin
                    m_addr = d_addr; m_wdata = d_wdata; m_we = d_we;
                    if (if_req) m_starve++;
                end else begin
                    m_addr = if_addr; m_we = 0; m_starve = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_read",  64'(mem_read),  64'(m_acc && (!m_is_d || !m_we)));
            check("mem_write", 64'(mem_write), 64'(m_acc && m_is_d && m_we));
            check("busy",      64'(busy),      64'(m_acc));
            check("if_done",   64'(if_done),   64'(e_if_done));
            check("d_done",    64'(d_done),    64'(e_d_done));
            check("if_rdata",  64'(if_rdata),  64'(e_if_rdata));
            check("d_rdata",   64'(d_rdata),   64'(e_d_rdata));
            check("strobe_excl", 64'(mem_read && mem_write), 64'(0));
            check("done_excl",   64'(if_done && d_done),     64'(0));
            if (m_acc) check("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (m_acc && m_is_d && m_we) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
    end

    // Raise one request, scramble its inputs mid-access, wait for its done and drop it.
    task automatic run_access(input bit dreq, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int n_rd, output int n_wr,
                              output int n_busy, output int done_at,
                              output logic [31:0] addr_mid, output logic [31:0] wdata_mid);
        @(negedge clk);
        if (dreq) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        n_rd = 0; n_wr = 0; n_busy = 0; done_at = -1;
        addr_mid = '0; wdata_mid = '0;
        for (int c = 1; c <= 40 && done_at < 0; c++) begin
            @(negedge clk);
            n_rd   += int'(mem_read);
            n_wr   += int'(mem_write);
            n_busy += int'(busy);
            if (c == 2) begin
                d_addr = ~addr; d_wdata = ~wdata; if_addr = ~addr;
            end
            if (c == 3) begin
                addr_mid = mem_addr; wdata_mid = mem_wdata;
            end
            if ((dreq && d_done) || (!dreq && if_done)) begin
                done_at = c;
                d_req = 0; if_req = 0;
            end
        end
    endtask

    initial begin
        int n_rd, n_wr, n_busy, done_at;
        logic [31:0] a_mid, w_mid;
        bit exp_seq[6];
        exp_seq = '{1, 1, 0, 1, 1, 0};

        reset = 1;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_mem_read",  64'(mem_read),  64'(0));
        check("rst_mem_write", 64'(mem_write), 64'(0));
        check("rst_busy",      64'(busy),      64'(0));
        check("rst_mem_addr",  64'(mem_addr),  64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_if_rdata",  64'(if_rdata),  64'(0));
        check("rst_d_rdata",   64'(d_rdata),   64'(0));
        reset = 0;

        // Fetch from 0x100.
        run_access(0, 0, 32'h100, 32'h0, n_rd, n_wr, n_busy, done_at, a_mid, w_mid);
        check("fetch_rd_cycles",   64'(n_rd),    64'(4));
        check("fetch_busy_cycles", 64'(n_busy),  64'(4));
        check("fetch_done_cycle",  64'(done_at), 64'(5));
        check("fetch_rdata",       64'(if_rdata), 64'h0050_0093);

        // Load from 0x40.
        run_access(1, 0, 32'h40, 32'h0, n_rd, n_wr, n_busy, done_at, a_mid, w_mid);
        check("load_rd_cycles",  64'(n_rd),    64'(4));
        check("load_wr_cycles",  64'(n_wr),    64'(0));
        check("load_done_cycle", 64'(done_at), 64'(5));
        check("load_rdata",      64'(d_rdata), 64'h1234_5678);

        // Fetch from 0x104 must not disturb d_rdata.
        run_access(0, 0, 32'h104, 32'h0, n_rd, n_wr, n_busy, done_at, a_mid, w_mid);
        check("fetch2_rdata",      64'(if_rdata), 64'h0000_ABCD);
        check("fetch2_keep_drdata", 64'(d_rdata), 64'h1234_5678);

        // Store with address/data changed mid-access.
        run_access(1, 1, 32'h2000, 32'hDEAD_BEEF, n_rd, n_wr, n_busy, done_at, a_mid, w_mid);
        check("store_wr_cycles",  64'(n_wr),    64'(4));
        check("store_rd_cycles",  64'(n_rd),    64'(0));
        check("store_done_cycle", 64'(done_at), 64'(5));
        check("store_addr_mid",   64'(a_mid),   64'h2000);
        check("store_wdata_mid",  64'(w_mid),   64'hDEAD_BEEF);
        check("store_keep_drdata", 64'(d_rdata), 64'h1234_5678);
        check("store_keep_ifrdata", 64'(if_rdata), 64'h0000_ABCD);

        // Both requesters held high: order D, D, IF, D, D, IF.
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h40; if_req = 1; if_addr = 32'h104;
        for (int c = 0; c < 200 && got.size() < 6; c++) begin
            @(negedge clk);
            if (d_done)  got.push_back(1);
            if (if_done) got.push_back(0);
        end
        d_req = 0; if_req = 0;
        check("arb_grant_count", 64'(got.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) check($sformatf("arb_grant_%0d", i), 64'(got[i]), 64'(exp_seq[i]));
        end

        // Reset in the 2nd access cycle of a load aborts it.
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h80;
        @(negedge clk);
        check("abort_busy_pre", 64'(busy), 64'(1));
        @(negedge clk);
        reset = 1; d_req = 0;
        @(negedge clk);
        check("abort_mem_read", 64'(mem_read), 64'(0));
        check("abort_busy",     64'(busy),     64'(0));
        check("abort_d_done",   64'(d_done),   64'(0));
        check("abort_d_rdata",  64'(d_rdata),  64'(0));
        reset = 0;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            check("abort_no_done", 64'(d_done), 64'(0));
        end

        // LATENCY=1: access, done, access, done, ...
        @(negedge clk);
        l1_if_req = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("l1_read_%0d", c), 64'(l1_mem_read), 64'((c % 2) == 0));
            check($sformatf("l1_busy_%0d", c), 64'(l1_busy),     64'((c % 2) == 0));
            check($sformatf("l1_done_%0d", c), 64'(l1_if_done),  64'((c % 2) == 1));
        end
        l1_if_req = 0;
        check("l1_rdata", 64'(l1_if_rdata), 64'hCAFE_0001);

        @(negedge clk);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
